// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer: FSM states, channel count
// and the active-low seven-segment glyphs (bits[7:1] = a..g, bit0 = dp).
package mux_scan_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } scan_state_e;

    localparam int NUM_CH = 4;

    localparam logic [7:0] SEG_0 = 8'h03;
    localparam logic [7:0] SEG_1 = 8'h9F;
    localparam logic [7:0] SEG_2 = 8'h25;
    localparam logic [7:0] SEG_3 = 8'h0D;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h49;
    localparam logic [7:0] SEG_6 = 8'h41;
    localparam logic [7:0] SEG_7 = 8'h1F;
    localparam logic [7:0] SEG_8 = 8'h01;
    localparam logic [7:0] SEG_9 = 8'h09;
    localparam logic [7:0] SEG_A = 8'h11;
    localparam logic [7:0] SEG_B = 8'hC1;
    localparam logic [7:0] SEG_C = 8'h63;
    localparam logic [7:0] SEG_D = 8'h85;
    localparam logic [7:0] SEG_E = 8'h61;
    localparam logic [7:0] SEG_F = 8'h71;

endpackage

// File: rtl/mux_scan_capture_seg_hex_decoder.sv
// Hex digit to active-low seven-segment pattern; decimal point always off.
module seg_hex_decoder
    import mux_scan_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [7:0] seg_o
);

    // Glyph lookup for one hex digit
    always_comb begin
        seg_o = SEG_0;
        case (digit_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            4'hF:    seg_o = SEG_F;
            default: seg_o = SEG_0;
        endcase
    end

endmodule

// File: rtl/mux_scan_capture.sv
// Scan sequencer around a 4-to-1 key-select mux. Drives the select, holds
// each select for SETTLE+1 cycles, captures the mux output on the expiry
// edge into a shadow buffer and publishes all four channels atomically on
// the final capture edge with valid/changed. Optional hex display outputs
// are built when MUX_SCAN_SEG_EN is defined.
module mux_scan_capture
    import mux_scan_pkg::*;
#(
    parameter int SEL_W  = 2,
    parameter int DATA_W = 2,
    parameter int SETTLE = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    input  logic                       cont,
    input  logic [DATA_W-1:0]          data_in,
    output logic [SEL_W-1:0]           sel,
    output logic [NUM_CH*DATA_W-1:0]   results,
    output logic                       valid,
    output logic                       changed,
    output logic                       busy
`ifdef MUX_SCAN_SEG_EN
    ,
    output logic [7:0]                 seg0,
    output logic [7:0]                 seg1,
    output logic [7:0]                 seg2,
    output logic [7:0]                 seg3
`endif
);

    localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_CH - 1);

    scan_state_e                state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [SEL_W-1:0]           sel_q, sel_d;
    logic [NUM_CH*DATA_W-1:0]   shadow_q, shadow_d;
    logic [NUM_CH*DATA_W-1:0]   results_q, results_d;
    logic                       valid_q, valid_d;
    logic                       changed_q, changed_d;
    logic                       busy_q, busy_d;
    logic [NUM_CH*DATA_W-1:0]   capture_s;

    // Shadow buffer with the current mux output dropped into the selected slot
    always_comb begin
        capture_s = shadow_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                capture_s[DATA_W*i +: DATA_W] = data_in;
            end else begin
                capture_s[DATA_W*i +: DATA_W] = shadow_q[DATA_W*i +: DATA_W];
            end
        end
    end

    // Next-state logic: settle countdown, capture on expiry, publish on last channel
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        shadow_d  = shadow_q;
        results_d = results_q;
        valid_d   = 1'b0;
        changed_d = changed_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HOLD;
                    sel_d   = {SEL_W{1'b0}};
                    cnt_d   = CNT_RELOAD;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shadow_d = capture_s;
                    cnt_d    = CNT_RELOAD;
                    if (sel_q != LAST_SEL) begin
                        sel_d = sel_q + SEL_W'(1);
                    end else begin
                        // Final capture: publish the whole snapshot in one edge
                        results_d = capture_s;
                        valid_d   = 1'b1;
                        changed_d = (capture_s != results_q);
                        sel_d     = {SEL_W{1'b0}};
                        if (cont) begin
                            busy_d = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                sel_d   = {SEL_W{1'b0}};
            end
        endcase
    end

    // State and output registers; asynchronous reset discards any partial scan
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            sel_q     <= {SEL_W{1'b0}};
            shadow_q  <= {(NUM_CH*DATA_W){1'b0}};
            results_q <= {(NUM_CH*DATA_W){1'b0}};
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            shadow_q  <= shadow_d;
            results_q <= results_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
        end
    end

    assign sel     = sel_q;
    assign results = results_q;
    assign valid   = valid_q;
    assign changed = changed_q;
    assign busy    = busy_q;

`ifdef MUX_SCAN_SEG_EN
    logic [3:0] digit_s [NUM_CH];

    // Zero-extend each published channel to a hex digit
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            digit_s[i] = 4'(results_q[DATA_W*i +: DATA_W]);
        end
    end

    seg_hex_decoder u_seg0 (.digit_i(digit_s[0]), .seg_o(seg0));
    seg_hex_decoder u_seg1 (.digit_i(digit_s[1]), .seg_o(seg1));
    seg_hex_decoder u_seg2 (.digit_i(digit_s[2]), .seg_o(seg2));
    seg_hex_decoder u_seg3 (.digit_i(digit_s[3]), .seg_o(seg3));
`endif

endmodule

// File: tb/tb_mux_scan_capture.sv
// Self-checking bench for mux_scan_capture (SETTLE=2, 12-cycle scans).
// Builds with or without MUX_SCAN_SEG_EN.
module tb_mux_scan_capture;

    logic       clk = 1'b0;
    logic       resetn, start, cont;
    logic [1:0] data_in;
    logic [1:0] sel;
    logic [7:0] results;
    logic       valid, changed, busy;
`ifdef MUX_SCAN_SEG_EN
    logic [7:0] seg0, seg1, seg2, seg3;
`endif

    logic [7:0] chan;
    logic       glitch;
    logic [7:0] prev_model;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    // Mux model: channel value addressed by sel, optionally corrupted on channel 1
    assign data_in = (glitch && sel == 2'd1) ? ~chan[{sel, 1'b0} +: 2] : chan[{sel, 1'b0} +: 2];

    mux_scan_capture #(.SEL_W(2), .DATA_W(2), .SETTLE(2)) dut (
        .clk(clk), .resetn(resetn), .start(start), .cont(cont), .data_in(data_in),
        .sel(sel), .results(results), .valid(valid), .changed(changed), .busy(busy)
`ifdef MUX_SCAN_SEG_EN
        , .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef MUX_SCAN_SEG_EN
    function automatic logic [7:0] seg_ref(input logic [1:0] d);
        logic [7:0] g;
        case (d)
            2'd0:    g = 8'h03;
            2'd1:    g = 8'h9F;
            2'd2:    g = 8'h25;
            default: g = 8'h0D;
        endcase
        return g;
    endfunction
`endif

    // One scan from start; k counts edges after the start edge E0.
    // Stimulus events happen #1 after edge k and are sampled at edge k+1.
    task automatic run_scan(input logic [7:0] vals, input logic [7:0] exp_res, input logic exp_chg,
                            input logic cont_i, input int clear_at, input int glitch_at,
                            input int restart_at);
        int   end_k;
        logic first;
        logic exp_v;
        end_k = cont_i ? ((clear_at / 12) + 1) * 12 : 12;
        chan  = vals;
        cont  = cont_i;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_at_e0", busy, 1);
        check("sel_at_e0", sel, 0);
        first = 1'b1;
        for (int k = 1; k <= end_k + 3; k++) begin
            @(posedge clk); #1;
            exp_v = (k % 12 == 0) && (k <= end_k);
            check("valid", valid, exp_v);
            check("busy", busy, (k < end_k));
            check("sel", sel, (k < end_k) ? (k % 12) / 3 : 0);
            if (exp_v) begin
                check("results", results, exp_res);
                check("changed", changed, first ? exp_chg : 1'b0);
                first = 1'b0;
`ifdef MUX_SCAN_SEG_EN
                check("seg0", seg0, seg_ref(exp_res[1:0]));
                check("seg1", seg1, seg_ref(exp_res[3:2]));
                check("seg2", seg2, seg_ref(exp_res[5:4]));
                check("seg3", seg3, seg_ref(exp_res[7:6]));
`endif
            end
            if (k == glitch_at)      glitch = 1'b1;
            if (k == glitch_at + 1)  glitch = 1'b0;
            if (k == restart_at - 1) start  = 1'b1;
            if (k == restart_at)     start  = 1'b0;
            if (k == clear_at)       cont   = 1'b0;
        end
        cont = 1'b0;
    endtask

    typedef struct {
        logic [1:0] c0, c1, c2, c3;
        logic [7:0] exp_res;
        logic       exp_chg;
        logic       cont_i;
        int         clear_at;
        int         glitch_at;
        int         restart_at;
    } vec_t;

    vec_t       tbl [9];
    logic [1:0] r [4];
    logic [7:0] rv, re;

    initial begin
        //          c0    c1    c2    c3    results chg   cont  clr gl  rs
        tbl[0] = '{2'd1, 2'd2, 2'd3, 2'd0, 8'h39, 1'b1, 1'b0, 0,  0,  0};
        tbl[1] = '{2'd1, 2'd2, 2'd3, 2'd0, 8'h39, 1'b0, 1'b0, 0,  0,  0};
        tbl[2] = '{2'd3, 2'd3, 2'd3, 2'd3, 8'hFF, 1'b1, 1'b0, 0,  0,  0};
        tbl[3] = '{2'd0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 1'b0, 0,  0,  0};
        tbl[4] = '{2'd0, 2'd1, 2'd2, 2'd3, 8'hE4, 1'b1, 1'b0, 0,  0,  0};
        tbl[5] = '{2'd2, 2'd0, 2'd1, 2'd3, 8'hD2, 1'b1, 1'b0, 0,  0,  0};
        tbl[6] = '{2'd1, 2'd2, 2'd3, 2'd0, 8'h39, 1'b1, 1'b1, 40, 0,  0};
        tbl[7] = '{2'd1, 2'd2, 2'd3, 2'd0, 8'h39, 1'b0, 1'b1, 20, 0,  0};
        tbl[8] = '{2'd1, 2'd2, 2'd3, 2'd0, 8'h39, 1'b0, 1'b0, 0,  4,  5};

        resetn = 1'b1; start = 1'b0; cont = 1'b0; chan = 8'h00; glitch = 1'b0;
        #3 resetn = 1'b0;
        #1;
        check("rst_sel", sel, 0);
        check("rst_results", results, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_changed", changed, 0);
`ifdef MUX_SCAN_SEG_EN
        check("rst_seg0", seg0, 8'h03);
        check("rst_seg3", seg3, 8'h03);
`endif
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_scan({tbl[i].c3, tbl[i].c2, tbl[i].c1, tbl[i].c0}, tbl[i].exp_res, tbl[i].exp_chg,
                     tbl[i].cont_i, tbl[i].clear_at, tbl[i].glitch_at, tbl[i].restart_at);
        end

        // Asynchronous reset in the middle of a scan, seen before any clock edge
        chan  = 8'hFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_sel", sel, 0);
        check("midrst_results", results, 8'h00);
        check("midrst_valid", valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_changed", changed, 0);
`ifdef MUX_SCAN_SEG_EN
        check("midrst_seg1", seg1, 8'h03);
`endif
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        run_scan(8'h39, 8'h39, 1'b1, 1'b0, 0, 0, 0);
        prev_model = 8'h39;

        // Random single scans checked against an arithmetic snapshot model
        for (int n = 0; n < 12; n++) begin
            for (int c = 0; c < 4; c++) r[c] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                for (int c = 0; c < 4; c++) r[c] = prev_model[2*c +: 2];
            end
            rv = {r[3], r[2], r[1], r[0]};
            re = 8'(int'(r[0]) + 4 * int'(r[1]) + 16 * int'(r[2]) + 64 * int'(r[3]));
            run_scan(rv, re, (re != prev_model), 1'b0, 0, 0, 0);
            prev_model = re;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
